// File: rtl/mac_accumulator_block.sv
// Four-lane accumulator behind the MAC combiner: independent, paired or fully chained
// lanes with preload, clear and sticky per-lane overflow flags.

module n_bit_cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Four-bit lookahead groups with the group carry rippled between them; WIDTH must be a multiple of 4.
  localparam int GROUPS = WIDTH / 4;

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [3:0]       g4;
  logic [3:0]       p4;
  logic [4:0]       c;
  logic             carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  always_comb begin
    // NOTE: blocking assignments here so carry flows group to group within one evaluation.
    sum   = '0;
    carry = cin;
    g4    = '0;
    p4    = '0;
    c     = '0;
    for (int grp = 0; grp < GROUPS; grp++) begin
      g4   = gen[grp*4 +: 4];
      p4   = prop[grp*4 +: 4];
      c[0] = carry;
      c[1] = g4[0] | (p4[0] & c[0]);
      c[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & c[0]);
      c[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0]) | (p4[2] & p4[1] & p4[0] & c[0]);
      c[4] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1]) |
             (p4[3] & p4[2] & p4[1] & g4[0]) | ((&p4) & c[0]);
      sum[grp*4 +: 4] = p4 ^ c[3:0];
      carry = c[4];
    end
    cout = carry;
  end

endmodule

module mac_accumulator_block #(
  parameter int MAC_CONF_WIDTH = 3,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_ACC_WIDTH  = 4 * MAC_MIN_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [MAC_CONF_WIDTH-1:0] cfg,
  input  logic                      in_valid,
  input  logic [MAC_ACC_WIDTH-1:0]  in0,
  input  logic [MAC_ACC_WIDTH-1:0]  in1,
  input  logic [MAC_ACC_WIDTH-1:0]  in2,
  input  logic [MAC_ACC_WIDTH-1:0]  in3,
  input  logic                      init_valid,
  input  logic [MAC_ACC_WIDTH-1:0]  init0,
  input  logic [MAC_ACC_WIDTH-1:0]  init1,
  input  logic [MAC_ACC_WIDTH-1:0]  init2,
  input  logic [MAC_ACC_WIDTH-1:0]  init3,
  input  logic                      acc_clear,
  output logic [MAC_ACC_WIDTH-1:0]  acc0,
  output logic [MAC_ACC_WIDTH-1:0]  acc1,
  output logic [MAC_ACC_WIDTH-1:0]  acc2,
  output logic [MAC_ACC_WIDTH-1:0]  acc3,
  output logic                      out_valid,
  output logic [3:0]                ovf
);

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_DUAL   = 2'b01,
    MODE_QUAD   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  mode_e mode;
  logic  chain_pair;
  logic  chain_quad;
  logic  load_mode;

  logic [MAC_ACC_WIDTH-1:0] sum0, sum1, sum2, sum3;
  logic cout0, cout1, cout2, cout3;
  logic cin1, cin2, cin3;
  logic [3:0] ovf_set;

  assign mode       = mode_e'(cfg[1:0]);
  assign load_mode  = cfg[2];
  assign chain_pair = (mode == MODE_DUAL) || (mode == MODE_QUAD);
  assign chain_quad = (mode == MODE_QUAD);

  // Lane 2 only takes lane 1's carry when all four lanes form one word.
  assign cin1 = chain_pair & cout0;
  assign cin2 = chain_quad & cout1;
  assign cin3 = chain_pair & cout2;

  n_bit_cla_adder #(.WIDTH(MAC_ACC_WIDTH)) u_add0 (
    .a(acc0), .b(in0), .cin(1'b0), .sum(sum0), .cout(cout0)
  );
  n_bit_cla_adder #(.WIDTH(MAC_ACC_WIDTH)) u_add1 (
    .a(acc1), .b(in1), .cin(cin1), .sum(sum1), .cout(cout1)
  );
  n_bit_cla_adder #(.WIDTH(MAC_ACC_WIDTH)) u_add2 (
    .a(acc2), .b(in2), .cin(cin2), .sum(sum2), .cout(cout2)
  );
  n_bit_cla_adder #(.WIDTH(MAC_ACC_WIDTH)) u_add3 (
    .a(acc3), .b(in3), .cin(cin3), .sum(sum3), .cout(cout3)
  );

  // Only the top lane of each chained group can lose its carry.
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves ovf_set unassigned (no latch).
    ovf_set = '0;
    case (mode)
      MODE_DUAL: ovf_set = {cout3, 1'b0, cout1, 1'b0};
      MODE_QUAD: ovf_set = {cout3, 3'b000};
      default:   ovf_set = {cout3, cout2, cout1, cout0};
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state so every register sees pre-edge values.
    if (rst) begin
      acc0      <= '0;
      acc1      <= '0;
      acc2      <= '0;
      acc3      <= '0;
      ovf       <= '0;
      out_valid <= 1'b0;
    end else if (!en) begin
      out_valid <= 1'b0;
    end else if (init_valid) begin
      acc0      <= init0;
      acc1      <= init1;
      acc2      <= init2;
      acc3      <= init3;
      ovf       <= '0;
      out_valid <= 1'b1;
    end else if (acc_clear) begin
      acc0      <= '0;
      acc1      <= '0;
      acc2      <= '0;
      acc3      <= '0;
      ovf       <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      if (load_mode) begin
        acc0 <= in0;
        acc1 <= in1;
        acc2 <= in2;
        acc3 <= in3;
      end else begin
        acc0 <= sum0;
        acc1 <= sum1;
        acc2 <= sum2;
        acc3 <= sum3;
        ovf  <= ovf | ovf_set;
      end
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_accumulator_block.sv
// Bench for mac_accumulator_block: a wide-arithmetic reference model feeds a scoreboard
// checked every cycle, plus directed scenario tasks with their own expectations.

module tb_mac_accumulator_block;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, init_valid, acc_clear;
  logic [2:0]  cfg;
  logic [31:0] in0, in1, in2, in3;
  logic [31:0] init0, init1, init2, init3;
  logic [31:0] acc0, acc1, acc2, acc3;
  logic        out_valid;
  logic [3:0]  ovf;
  logic [127:0] acc_all;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [127:0] acc;
    logic [3:0]   ovf;
    logic         ov;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_acc[4];
  logic [3:0]  m_ovf = '0;

  always #5 clk = ~clk;

  assign acc_all = {acc3, acc2, acc1, acc0};

  mac_accumulator_block dut (
    .clk(clk), .rst(rst), .en(en), .cfg(cfg), .in_valid(in_valid),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .init_valid(init_valid),
    .init0(init0), .init1(init1), .init2(init2), .init3(init3),
    .acc_clear(acc_clear),
    .acc0(acc0), .acc1(acc1), .acc2(acc2), .acc3(acc3),
    .out_valid(out_valid), .ovf(ovf)
  );

  // Reference model: lanes grouped into 32/64/128-bit words with ordinary wide additions.
  task automatic tick();
    exp_t         e;
    logic         ov;
    logic [32:0]  s33;
    logic [64:0]  s65;
    logic [128:0] s129;
    ov = 1'b0;
    if (rst) begin
      for (int k = 0; k < 4; k++) m_acc[k] = '0;
      m_ovf = '0;
    end else if (!en) begin
      ov = 1'b0;
    end else if (init_valid) begin
      m_acc[0] = init0; m_acc[1] = init1; m_acc[2] = init2; m_acc[3] = init3;
      m_ovf = '0;
      ov = 1'b1;
    end else if (acc_clear) begin
      for (int k = 0; k < 4; k++) m_acc[k] = '0;
      m_ovf = '0;
    end else if (in_valid) begin
      ov = 1'b1;
      if (cfg[2]) begin
        m_acc[0] = in0; m_acc[1] = in1; m_acc[2] = in2; m_acc[3] = in3;
      end else if (cfg[1:0] == 2'b01) begin
        s65 = {33'd0, m_acc[1], m_acc[0]} + {33'd0, in1, in0};
        {m_acc[1], m_acc[0]} = s65[63:0];
        m_ovf[1] = m_ovf[1] | s65[64];
        s65 = {33'd0, m_acc[3], m_acc[2]} + {33'd0, in3, in2};
        {m_acc[3], m_acc[2]} = s65[63:0];
        m_ovf[3] = m_ovf[3] | s65[64];
      end else if (cfg[1:0] == 2'b10) begin
        s129 = {1'b0, m_acc[3], m_acc[2], m_acc[1], m_acc[0]} + {1'b0, in3, in2, in1, in0};
        {m_acc[3], m_acc[2], m_acc[1], m_acc[0]} = s129[127:0];
        m_ovf[3] = m_ovf[3] | s129[128];
      end else begin
        s33 = {1'b0, m_acc[0]} + {1'b0, in0}; m_acc[0] = s33[31:0]; m_ovf[0] = m_ovf[0] | s33[32];
        s33 = {1'b0, m_acc[1]} + {1'b0, in1}; m_acc[1] = s33[31:0]; m_ovf[1] = m_ovf[1] | s33[32];
        s33 = {1'b0, m_acc[2]} + {1'b0, in2}; m_acc[2] = s33[31:0]; m_ovf[2] = m_ovf[2] | s33[32];
        s33 = {1'b0, m_acc[3]} + {1'b0, in3}; m_acc[3] = s33[31:0]; m_ovf[3] = m_ovf[3] | s33[32];
      end
    end
    e.acc = {m_acc[3], m_acc[2], m_acc[1], m_acc[0]};
    e.ovf = m_ovf;
    e.ov  = ov;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
  endtask

  exp_t want;
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      want = sb.pop_front();
      checks++;
      if ({acc_all, ovf, out_valid} !== {want.acc, want.ovf, want.ov}) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got acc=%h ovf=%b ov=%b expected acc=%h ovf=%b ov=%b",
                 $time, acc_all, ovf, out_valid, want.acc, want.ovf, want.ov);
      end
    end
  end

  task automatic idle_inputs();
    rst = 1'b0; en = 1'b1; cfg = 3'b000;
    in_valid = 1'b0; init_valid = 1'b0; acc_clear = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    init0 = '0; init1 = '0; init2 = '0; init3 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; in_valid = 1'b1;
    in0 = '1; in1 = '1; in2 = '1; in3 = '1;
    tick(); tick();
    checks++;
    if ({acc_all, ovf, out_valid} !== '0) begin
      errors++;
      $display("FAIL reset_state: got acc=%h ovf=%b ov=%b expected all zero", acc_all, ovf, out_valid);
    end
    idle_inputs();
    tick();
    checks++;
    if ({acc_all, ovf, out_valid} !== '0) begin
      errors++;
      $display("FAIL reset_release: got acc=%h ovf=%b ov=%b expected all zero", acc_all, ovf, out_valid);
    end
  endtask

  task automatic test_single_wrap();
    idle_inputs();
    init_valid = 1'b1;
    init0 = 32'hFFFF_FFF0; init1 = 32'hFFFF_FFF0; init2 = 32'hFFFF_FFF0; init3 = 32'hFFFF_FFF0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || acc0 !== 32'hFFFF_FFF0) begin
      errors++;
      $display("FAIL single_init: got acc0=%h ov=%b expected fffffff0 1", acc0, out_valid);
    end
    idle_inputs();
    in_valid = 1'b1; in0 = 32'h20; in1 = 32'h20; in2 = 32'h20; in3 = 32'h20;
    tick();
    checks++;
    if ({acc_all, ovf, out_valid} !== {{4{32'h0000_0010}}, 4'b1111, 1'b1}) begin
      errors++;
      $display("FAIL single_wrap: got acc=%h ovf=%b ov=%b expected 4x00000010 1111 1", acc_all, ovf, out_valid);
    end
    idle_inputs();
    tick();
    checks++;
    if (out_valid !== 1'b0 || ovf !== 4'b1111) begin
      errors++;
      $display("FAIL single_sticky: got ov=%b ovf=%b expected 0 1111", out_valid, ovf);
    end
  endtask

  task automatic test_dual();
    idle_inputs();
    cfg = 3'b001; init_valid = 1'b1; init0 = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    cfg = 3'b001; in_valid = 1'b1; in0 = 32'd1;
    tick();
    checks++;
    if ({acc_all, ovf} !== {32'd0, 32'd0, 32'd1, 32'd0, 4'b0000}) begin
      errors++;
      $display("FAIL dual_chain: got acc=%h ovf=%b expected acc1=1 rest 0 ovf 0000", acc_all, ovf);
    end
    acc_clear = 1'b1; in0 = 32'd5;
    tick();
    checks++;
    if ({acc_all, out_valid} !== '0) begin
      errors++;
      $display("FAIL dual_clear: got acc=%h ov=%b expected all zero", acc_all, out_valid);
    end
  endtask

  task automatic test_quad();
    idle_inputs();
    cfg = 3'b010; init_valid = 1'b1;
    init0 = 32'hFFFF_FFFF; init1 = 32'hFFFF_FFFF; init2 = 32'hFFFF_FFFF; init3 = 32'h7FFF_FFFF;
    tick();
    idle_inputs();
    cfg = 3'b010; in_valid = 1'b1; in0 = 32'd1;
    tick();
    checks++;
    if ({acc_all, ovf} !== {32'h8000_0000, 96'd0, 4'b0000}) begin
      errors++;
      $display("FAIL quad_carry: got acc=%h ovf=%b expected 80000000_0_0_0 0000", acc_all, ovf);
    end
    in0 = 32'd0; in3 = 32'h8000_0000;
    tick();
    checks++;
    if ({acc_all, ovf} !== {128'd0, 4'b1000}) begin
      errors++;
      $display("FAIL quad_ovf: got acc=%h ovf=%b expected 0 1000", acc_all, ovf);
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    acc_clear = 1'b1;
    tick();
    idle_inputs();
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1; in0 = i;
      tick();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_valid[%0d]: got ov=%b expected 1", i, out_valid);
      end
    end
    idle_inputs();
    checks++;
    if (acc0 !== 32'd55) begin
      errors++;
      $display("FAIL b2b_sum: got acc0=%0d expected 55", acc0);
    end
    acc_clear = 1'b1;
    tick();
    idle_inputs();
    for (int i = 1; i <= 10; i++) begin
      if (i == 6) begin
        for (int s = 0; s < 3; s++) begin
          en = 1'b0; in_valid = 1'b1; in0 = 32'd100;
          tick();
          checks++;
          if (out_valid !== 1'b0 || acc0 !== 32'd15) begin
            errors++;
            $display("FAIL stall[%0d]: got ov=%b acc0=%0d expected 0 15", s, out_valid, acc0);
          end
        end
        en = 1'b1;
      end
      in_valid = 1'b1; in0 = i;
      tick();
    end
    idle_inputs();
    checks++;
    if (acc0 !== 32'd55 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_sum: got acc0=%0d ov=%b expected 55 1", acc0, out_valid);
    end
  endtask

  task automatic test_load_reserved();
    idle_inputs();
    cfg = 3'b100; in_valid = 1'b1;
    in3 = 32'd4; in2 = 32'd3; in1 = 32'd2; in0 = 32'd1;
    tick();
    checks++;
    if ({acc_all, ovf} !== {32'd4, 32'd3, 32'd2, 32'd1, 4'b0000}) begin
      errors++;
      $display("FAIL load_mode: got acc=%h ovf=%b expected 4_3_2_1 0000", acc_all, ovf);
    end
    idle_inputs();
    cfg = 3'b011; in_valid = 1'b1; in0 = 32'hFFFF_FFFF;
    tick();
    checks++;
    if ({acc_all, ovf} !== {32'd4, 32'd3, 32'd2, 32'd0, 4'b0001}) begin
      errors++;
      $display("FAIL reserved_mode: got acc=%h ovf=%b expected 4_3_2_0 0001", acc_all, ovf);
    end
  endtask

  task automatic test_priority();
    idle_inputs();
    init_valid = 1'b1; acc_clear = 1'b1; in_valid = 1'b1; in0 = 32'd1;
    init0 = 32'd11; init1 = 32'd22; init2 = 32'd33; init3 = 32'd44;
    tick();
    checks++;
    if ({acc_all, ovf, out_valid} !== {32'd44, 32'd33, 32'd22, 32'd11, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL init_wins: got acc=%h ovf=%b ov=%b expected 44_33_22_11 0000 1", acc_all, ovf, out_valid);
    end
    en = 1'b0; init0 = 32'd99;
    tick();
    checks++;
    if (acc0 !== 32'd11 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_hold: got acc0=%0d ov=%b expected 11 0", acc0, out_valid);
    end
    idle_inputs();
    rst = 1'b1; en = 1'b0; in_valid = 1'b1; in0 = 32'd7;
    tick();
    checks++;
    if ({acc_all, ovf, out_valid} !== '0) begin
      errors++;
      $display("FAIL rst_midstream: got acc=%h ovf=%b ov=%b expected all zero", acc_all, ovf, out_valid);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int n = 0; n < 200; n++) begin
      rst        = ($urandom_range(0, 39) == 0);
      en         = ($urandom_range(0, 7) != 0);
      init_valid = ($urandom_range(0, 9) == 0);
      acc_clear  = ($urandom_range(0, 11) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      cfg        = 3'($urandom_range(0, 7));
      in0 = ($urandom_range(0, 1) != 0) ? $urandom : 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      in1 = $urandom; in2 = $urandom;
      in3 = ($urandom_range(0, 1) != 0) ? $urandom : 32'hFFFF_FFFF;
      init0 = $urandom; init1 = $urandom; init2 = $urandom; init3 = $urandom;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) m_acc[k] = '0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_wrap();
    test_dual();
    test_quad();
    test_back_to_back();
    test_load_reserved();
    test_priority();
    test_random();
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
